excp_ctrl: RTL

- Exception and interrupt sequencer between the mem1 commit point and the CSR register file.
- Samples interrupt pending state and commit-stage exception or ertn events, then selects one event.
- Drives the single-cycle CSR exception write request or the ertn strobe, plus pipeline flush and PC redirect.
- Holds commit stalled until the sequence completes.

---
 rtl/excp_ctrl_pkg.sv | 71 +++++++
 rtl/excp_prio_sel.sv | 44 ++++
 rtl/excp_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/excp_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
// The optional statistics counters are enabled by the EXCP_CTRL_STAT_EN macro.
package excp_ctrl_pkg;

    localparam int unsigned IS_WID       = 13;
    localparam int unsigned ESTAT_CODE_W = 15;

    localparam int unsigned ECODE_INT  = 32'h00;
    localparam int unsigned ECODE_PIL  = 32'h01;
    localparam int unsigned ECODE_PIS  = 32'h02;
    localparam int unsigned ECODE_PIF  = 32'h03;
    localparam int unsigned ECODE_PME  = 32'h04;
    localparam int unsigned ECODE_PPI  = 32'h07;
    localparam int unsigned ECODE_ADEF = 32'h08;
    localparam int unsigned ECODE_ALE  = 32'h09;
    localparam int unsigned ECODE_TLBR = 32'h3F;

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH, DRAIN} excp_state_t;
    typedef enum logic [1:0] {EvNone, EvInt, EvExcp, EvErtn} excp_ev_t;

    typedef struct packed {
        logic [1:0] plv;
        logic       ie;
    } crmd_t;

    typedef struct packed {
        logic [1:0] pplv;
        logic       pie;
    } prmd_t;

    typedef struct packed {
        logic [ESTAT_CODE_W-1:0] r_esubcode_ecode;
        logic [IS_WID-1:0]       is;
    } estat_t;

    typedef struct packed {
        logic [IS_WID-1:0] lie;
    } ecfg_t;

    typedef struct packed {
        crmd_t       crmd;
        prmd_t       prmd;
        estat_t      estat;
        ecfg_t       ecfg;
        logic [31:0] era;
        logic [31:0] badv;
        logic [31:0] eentry;
        logic [31:0] tlbrentry;
    } csr_t;

    typedef struct packed {
        logic [ESTAT_CODE_W-1:0] r_esubcode_ecode;
    } wr_estat_t;

    typedef struct packed {
        logic        we;
        crmd_t       crmd;
        prmd_t       prmd;
        wr_estat_t   estat;
        logic [31:0] era;
        logic [31:0] badv;
    } excp_wr_csr_req_t;

    // Address-related exceptions record the faulting address in BADV.
    function automatic logic badv_upd(input int unsigned code);
        return code == ECODE_PIL || code == ECODE_PIS || code == ECODE_PIF ||
               code == ECODE_PME || code == ECODE_PPI || code == ECODE_ADEF ||
               code == ECODE_ALE || code == ECODE_TLBR;
    endfunction

endpackage

// File: rtl/excp_prio_sel.sv
// Combinational event selection: interrupt > exception > ertn on a valid commit.
module excp_prio_sel
    import excp_ctrl_pkg::*;
#(
    parameter int unsigned ECODE_WID = 6,
    parameter int unsigned ESUB_WID  = 9
) (
    input  logic                 commit_valid_i,
    input  logic                 commit_excp_i,
    input  logic                 commit_ertn_i,
    input  logic [ECODE_WID-1:0] commit_ecode_i,
    input  logic [ESUB_WID-1:0]  commit_esubcode_i,
    input  logic                 crmd_ie_i,
    input  logic [IS_WID-1:0]    estat_is_i,
    input  logic [IS_WID-1:0]    ecfg_lie_i,
    output excp_ev_t             ev_o,
    output logic [ECODE_WID-1:0] ecode_o,
    output logic [ESUB_WID-1:0]  esubcode_o,
    output logic                 badv_upd_o
);

    logic int_req;
    assign int_req = crmd_ie_i & (|(estat_is_i & ecfg_lie_i));

    always_comb begin
        ev_o       = EvNone;
        ecode_o    = '0;
        esubcode_o = '0;
        if (commit_valid_i) begin
            if (int_req) begin
                ev_o    = EvInt;
                ecode_o = ECODE_WID'(ECODE_INT);
            end else if (commit_excp_i) begin
                ev_o       = EvExcp;
                ecode_o    = commit_ecode_i;
                esubcode_o = commit_esubcode_i;
            end else if (commit_ertn_i) begin
                ev_o = EvErtn;
            end
        end
        badv_upd_o = (ev_o == EvExcp) && badv_upd(32'(ecode_o));
    end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer: accept, one-cycle CSR write, flush, drain.
// Define EXCP_CTRL_STAT_EN to add the excp_cnt/int_cnt statistics ports.
module excp_ctrl
    import excp_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned ECODE_WID = 6,
    parameter int unsigned ESUB_WID  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit_valid,
    input  logic                 commit_excp,
    input  logic [ECODE_WID-1:0] commit_ecode,
    input  logic [ESUB_WID-1:0]  commit_esubcode,
    input  logic [31:0]          commit_pc,
    input  logic [31:0]          commit_badv,
    input  logic                 commit_ertn,
    input  csr_t                 csr_rd,
    output excp_wr_csr_req_t     excp_wr_req,
`ifdef EXCP_CTRL_STAT_EN
    output logic [31:0]          excp_cnt,
    output logic [31:0]          int_cnt,
`endif
    output logic                 is_ertn,
    output logic                 kill,
    output logic                 stall_commit,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc
);

    excp_state_t          state_q, state_d;
    excp_ev_t             ev_q, sel_ev;
    logic [ECODE_WID-1:0] ecode_q, sel_ecode;
    logic [ESUB_WID-1:0]  esub_q, sel_esub;
    logic [31:0]          pc_q, badv_q;
    logic [1:0]           plv_q;
    logic                 ie_q, badv_upd_q, sel_badv_upd, accept;
    logic [2:0]           cnt_q, cnt_d;

    logic unused_csr;
    assign unused_csr = ^{csr_rd.prmd, csr_rd.estat.r_esubcode_ecode};

    excp_prio_sel #(
        .ECODE_WID(ECODE_WID),
        .ESUB_WID (ESUB_WID)
    ) u_prio_sel (
        .commit_valid_i   (commit_valid),
        .commit_excp_i    (commit_excp),
        .commit_ertn_i    (commit_ertn),
        .commit_ecode_i   (commit_ecode),
        .commit_esubcode_i(commit_esubcode),
        .crmd_ie_i        (csr_rd.crmd.ie),
        .estat_is_i       (csr_rd.estat.is),
        .ecfg_lie_i       (csr_rd.ecfg.lie),
        .ev_o             (sel_ev),
        .ecode_o          (sel_ecode),
        .esubcode_o       (sel_esub),
        .badv_upd_o       (sel_badv_upd)
    );

    // rst_n gating keeps kill/stall low while reset is asserted.
    assign accept = rst_n && (state_q == IDLE) && (sel_ev != EvNone);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        excp_wr_req    = '0;
        is_ertn        = 1'b0;
        kill           = 1'b0;
        stall_commit   = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    kill         = 1'b1;
                    stall_commit = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                stall_commit   = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                if (ev_q == EvErtn) begin
                    is_ertn     = 1'b1;
                    redirect_pc = csr_rd.era;
                end else begin
                    excp_wr_req.we        = 1'b1;
                    excp_wr_req.prmd.pplv = plv_q;
                    excp_wr_req.prmd.pie  = ie_q;
                    excp_wr_req.estat.r_esubcode_ecode = ESTAT_CODE_W'({esub_q, ecode_q});
                    excp_wr_req.era       = pc_q;
                    excp_wr_req.badv      = badv_upd_q ? badv_q : csr_rd.badv;
                    redirect_pc = (32'(ecode_q) == ECODE_TLBR) ? csr_rd.tlbrentry
                                                               : csr_rd.eentry;
                end
                cnt_d   = 3'd1;
                state_d = (FLUSH_CYC > 1) ? FLUSH : DRAIN;
            end
            FLUSH: begin
                stall_commit = 1'b1;
                flush        = 1'b1;
                cnt_d        = cnt_q + 3'd1;
                if (cnt_d == 3'(FLUSH_CYC)) state_d = DRAIN;
            end
            DRAIN: begin
                stall_commit = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ev_q       <= EvNone;
            ecode_q    <= '0;
            esub_q     <= '0;
            pc_q       <= '0;
            badv_q     <= '0;
            plv_q      <= '0;
            ie_q       <= 1'b0;
            badv_upd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ev_q       <= sel_ev;
                ecode_q    <= sel_ecode;
                esub_q     <= sel_esub;
                pc_q       <= commit_pc;
                badv_q     <= commit_badv;
                plv_q      <= csr_rd.crmd.plv;
                ie_q       <= csr_rd.crmd.ie;
                badv_upd_q <= sel_badv_upd;
            end
        end
    end

`ifdef EXCP_CTRL_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excp_cnt <= '0;
            int_cnt  <= '0;
        end else if (state_q == WRITE) begin
            if (ev_q == EvExcp) excp_cnt <= excp_cnt + 32'd1;
            if (ev_q == EvInt)  int_cnt  <= int_cnt + 32'd1;
        end
    end
`endif

endmodule
